// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter_pkg
// Brief    : Shared types and constants for the two-port RAM arbiter.
// Revision : 1.0  initial release
// ============================================================================
package ram_arbiter_pkg;

    typedef enum logic [0:0] {
        RR    = 1'b0,
        LOCK1 = 1'b1
    } arb_state_t;

    localparam int   MAX_WAIT_DEFAULT = 4;

    localparam logic P_CPU = 1'b0;
    localparam logic P_LDR = 1'b1;

endpackage : ram_arbiter_pkg
`default_nettype wire

// File: rtl/ram_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Two-way round-robin picker producing a one-hot grant.
// Revision : 1.0  initial release
// ============================================================================
module rr_pick
    import ram_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt[P_CPU] = 1'b1;
            2'b10:   o_gnt[P_LDR] = 1'b1;
            // On a tie the port that did not win last time goes first
            2'b11:   o_gnt = (i_last == P_LDR) ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Brief    : Round-robin arbiter sharing one synchronous RAM between the CPU
//            and the loader port, with loader lock and CPU starvation guard.
// Revision : 1.0  initial release
// ============================================================================
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              lock1,
    output logic              ram_w_en,
    output logic [ADDR_W-1:0] ram_r_addr,
    output logic [ADDR_W-1:0] ram_w_addr,
    output logic [DATA_W-1:0] ram_w_data,
    input  logic [DATA_W-1:0] ram_r_data
);

    localparam logic [3:0] c_max_wait = 4'(MAX_WAIT);

    arb_state_t r_state;
    arb_state_t w_next_state;
    logic       r_last;
    logic [3:0] r_wait_cnt;
    logic       r_rvalid0;
    logic       r_rvalid1;
    logic [1:0] w_rr_gnt;
    logic       w_locked;
    logic       w_forced;
    logic       w_gnt0;
    logic       w_gnt1;

    rr_pick u_rr_pick (
        .i_req  ({req1, req0}),
        .i_last (r_last),
        .o_gnt  (w_rr_gnt)
    );

    // The cycle lock1 drops is already arbitrated round-robin
    assign w_locked = (r_state == LOCK1) && lock1;
    assign w_forced = w_locked && req0 && (r_wait_cnt >= c_max_wait);

    always_comb begin
        w_gnt0       = 1'b0;
        w_gnt1       = 1'b0;
        w_next_state = r_state;
        if (!rst) begin
            if (w_locked) begin
                if (w_forced) begin
                    w_gnt0 = 1'b1;
                end else if (req1) begin
                    w_gnt1 = 1'b1;
                end else begin
                    w_gnt0 = req0;
                end
            end else begin
                w_gnt0 = w_rr_gnt[P_CPU];
                w_gnt1 = w_rr_gnt[P_LDR];
            end
        end
        case (r_state)
            RR:      if (w_gnt1 && lock1) w_next_state = LOCK1;
            LOCK1:   if (!lock1)          w_next_state = RR;
            default: w_next_state = RR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RR;
            r_last     <= P_LDR;
            r_wait_cnt <= 4'd0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_gnt0) begin
                r_last <= P_CPU;
            end else if (w_gnt1) begin
                r_last <= P_LDR;
            end
            if (!w_locked || w_gnt0) begin
                r_wait_cnt <= 4'd0;
            end else if (req0 && (r_wait_cnt < c_max_wait)) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end
            r_rvalid0 <= w_gnt0 & ~we0;
            r_rvalid1 <= w_gnt1 & ~we1;
        end
    end

    assign gnt0       = w_gnt0;
    assign gnt1       = w_gnt1;
    assign rvalid0    = r_rvalid0;
    assign rvalid1    = r_rvalid1;
    assign rdata0     = ram_r_data;
    assign rdata1     = ram_r_data;
    assign ram_w_en   = w_gnt0 ? we0 : (w_gnt1 ? we1 : 1'b0);
    assign ram_r_addr = w_gnt1 ? addr1 : addr0;
    assign ram_w_addr = w_gnt1 ? addr1 : addr0;
    assign ram_w_data = w_gnt1 ? wdata1 : wdata0;

endmodule : ram_arbiter
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Brief    : Directed vector bench for ram_arbiter with a behavioural RAM.
// Revision : 1.0  initial release
// ============================================================================
module tb_ram_arbiter;

    typedef struct {
        logic        req0, we0;
        logic [7:0]  addr0;
        logic [15:0] wdata0;
        logic        req1, we1;
        logic [7:0]  addr1;
        logic [15:0] wdata1;
        logic        lock1;
        logic        g0, g1, wen, rv0, rv1;
        logic [15:0] rd;
        logic [3:0]  wt;
        logic        st;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, we0, req1, we1, lock1;
    logic [7:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata0, rdata1;
    logic        ram_w_en;
    logic [7:0]  ram_r_addr, ram_w_addr;
    logic [15:0] ram_w_data;
    logic [15:0] ram_r_data;

    logic [15:0] mem [256];
    vec_t        vecs [25];
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(8), .DATA_W(16), .MAX_WAIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0       (req0),
        .we0        (we0),
        .addr0      (addr0),
        .wdata0     (wdata0),
        .gnt0       (gnt0),
        .rvalid0    (rvalid0),
        .rdata0     (rdata0),
        .req1       (req1),
        .we1        (we1),
        .addr1      (addr1),
        .wdata1     (wdata1),
        .gnt1       (gnt1),
        .rvalid1    (rvalid1),
        .rdata1     (rdata1),
        .lock1      (lock1),
        .ram_w_en   (ram_w_en),
        .ram_r_addr (ram_r_addr),
        .ram_w_addr (ram_w_addr),
        .ram_w_data (ram_w_data),
        .ram_r_data (ram_r_data)
    );

    function automatic logic [15:0] init_word(int a);
        case (a)
            8'h10:   return 16'h1234;
            8'h11:   return 16'h5678;
            8'h12:   return 16'hA5A5;
            8'h13:   return 16'h0F0F;
            default: return 16'h0000;
        endcase
    endfunction

    // Behavioural 256x16 synchronous RAM; contents reload while rst is high
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (ram_w_en) begin
            mem[ram_w_addr] <= ram_w_data;
        end
        ram_r_data <= mem[ram_r_addr];
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic vec_t mk(
        input logic r0, w0, input logic [7:0] a0, input logic [15:0] d0,
        input logic r1, w1, input logic [7:0] a1, input logic [15:0] d1,
        input logic lk, g0, g1, wen, rv0, rv1, input logic [15:0] rd,
        input logic [3:0] wt, input logic st);
        vec_t v;
        v.req0 = r0; v.we0 = w0; v.addr0 = a0; v.wdata0 = d0;
        v.req1 = r1; v.we1 = w1; v.addr1 = a1; v.wdata1 = d1;
        v.lock1 = lk; v.g0 = g0; v.g1 = g1; v.wen = wen;
        v.rv0 = rv0; v.rv1 = rv1; v.rd = rd; v.wt = wt; v.st = st;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        req0 = v.req0; we0 = v.we0; addr0 = v.addr0; wdata0 = v.wdata0;
        req1 = v.req1; we1 = v.we1; addr1 = v.addr1; wdata1 = v.wdata1;
        lock1 = v.lock1;
    endtask

    initial begin
        //           r0 w0 a0     d0        r1 w1 a1     d1        lk g0 g1 we rv0 rv1 rd        wt st
        vecs[0]  = mk(0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0);
        vecs[1]  = mk(1, 0, 8'h10, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 1, 0, 0, 0, 0, 16'h0000, 0, 0);
        vecs[2]  = mk(0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 1, 0, 16'h1234, 0, 0);
        vecs[3]  = mk(0, 0, 8'h00, 16'h0000, 1, 0, 8'h11, 16'h0000, 0, 0, 1, 0, 0, 0, 16'h0000, 0, 0);
        vecs[4]  = mk(1, 0, 8'h12, 16'h0000, 1, 0, 8'h13, 16'h0000, 0, 1, 0, 0, 0, 1, 16'h5678, 0, 0);
        vecs[5]  = mk(1, 0, 8'h12, 16'h0000, 1, 0, 8'h13, 16'h0000, 0, 0, 1, 0, 1, 0, 16'hA5A5, 0, 0);
        vecs[6]  = mk(1, 0, 8'h12, 16'h0000, 1, 0, 8'h13, 16'h0000, 0, 1, 0, 0, 0, 1, 16'h0F0F, 0, 0);
        vecs[7]  = mk(1, 0, 8'h12, 16'h0000, 1, 0, 8'h13, 16'h0000, 0, 0, 1, 0, 1, 0, 16'hA5A5, 0, 0);
        vecs[8]  = mk(0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 0, 1, 16'h0F0F, 0, 0);
        vecs[9]  = mk(0, 0, 8'h00, 16'h0000, 1, 1, 8'h20, 16'hBEEF, 0, 0, 1, 1, 0, 0, 16'h0000, 0, 0);
        vecs[10] = mk(1, 0, 8'h20, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 1, 0, 0, 0, 0, 16'h0000, 0, 0);
        vecs[11] = mk(0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 1, 0, 16'hBEEF, 0, 0);
        vecs[12] = mk(0, 0, 8'h00, 16'h0000, 1, 0, 8'h11, 16'h0000, 1, 0, 1, 0, 0, 0, 16'h0000, 0, 0);
        vecs[13] = mk(1, 0, 8'h12, 16'h0000, 1, 0, 8'h11, 16'h0000, 1, 0, 1, 0, 0, 1, 16'h5678, 0, 1);
        vecs[14] = mk(1, 0, 8'h12, 16'h0000, 1, 0, 8'h11, 16'h0000, 1, 0, 1, 0, 0, 1, 16'h5678, 1, 1);
        vecs[15] = mk(1, 0, 8'h12, 16'h0000, 1, 0, 8'h11, 16'h0000, 1, 0, 1, 0, 0, 1, 16'h5678, 2, 1);
        vecs[16] = mk(1, 0, 8'h12, 16'h0000, 1, 0, 8'h11, 16'h0000, 1, 0, 1, 0, 0, 1, 16'h5678, 3, 1);
        vecs[17] = mk(1, 0, 8'h12, 16'h0000, 1, 0, 8'h11, 16'h0000, 1, 1, 0, 0, 0, 1, 16'h5678, 4, 1);
        vecs[18] = mk(0, 0, 8'h00, 16'h0000, 1, 0, 8'h11, 16'h0000, 1, 0, 1, 0, 1, 0, 16'hA5A5, 0, 1);
        vecs[19] = mk(1, 1, 8'h30, 16'hDEAD, 1, 0, 8'h11, 16'h0000, 1, 0, 1, 0, 0, 1, 16'h5678, 0, 1);
        vecs[20] = mk(1, 1, 8'h30, 16'hDEAD, 1, 0, 8'h11, 16'h0000, 1, 0, 1, 0, 0, 1, 16'h5678, 1, 1);
        vecs[21] = mk(0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 0, 0, 1, 16'h5678, 2, 1);
        vecs[22] = mk(0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h0000, 2, 1);
        vecs[23] = mk(0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 2, 1);
        vecs[24] = mk(0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0);

        // Reset with an active write request: nothing may reach the RAM
        rst = 1'b1;
        drive(mk(1, 1, 8'h40, 16'h1111, 1, 1, 8'h41, 16'h2222, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst gnt0", 32'(gnt0), 0);
        chk("rst gnt1", 32'(gnt1), 0);
        chk("rst wen", 32'(ram_w_en), 0);
        chk("rst rvalid0", 32'(rvalid0), 0);
        chk("rst rvalid1", 32'(rvalid1), 0);
        chk("rst state", 32'(dut.r_state), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(vecs[0]);

        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            @(negedge clk);
            chk($sformatf("v%0d gnt0", i), 32'(gnt0), 32'(vecs[i].g0));
            chk($sformatf("v%0d gnt1", i), 32'(gnt1), 32'(vecs[i].g1));
            chk($sformatf("v%0d wen", i), 32'(ram_w_en), 32'(vecs[i].wen));
            chk($sformatf("v%0d rvalid0", i), 32'(rvalid0), 32'(vecs[i].rv0));
            chk($sformatf("v%0d rvalid1", i), 32'(rvalid1), 32'(vecs[i].rv1));
            if (vecs[i].rv0) chk($sformatf("v%0d rdata0", i), 32'(rdata0), 32'(vecs[i].rd));
            if (vecs[i].rv1) chk($sformatf("v%0d rdata1", i), 32'(rdata1), 32'(vecs[i].rd));
            chk($sformatf("v%0d wait_cnt", i), 32'(dut.r_wait_cnt), 32'(vecs[i].wt));
            chk($sformatf("v%0d state", i), 32'(dut.r_state), 32'(vecs[i].st));
        end
        chk("mem30 untouched", 32'(mem[8'h30]), 0);
        chk("mem20 written", 32'(mem[8'h20]), 32'h0000BEEF);

        // Enter LOCK1, then pulse rst in the cycle of a port-1 read grant
        @(posedge clk);
        #1;
        drive(mk(0, 0, 8'h00, 16'h0000, 1, 0, 8'h11, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("lk gnt1", 32'(gnt1), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst gnt1", 32'(gnt1), 0);
        chk("midrst rvalid1", 32'(rvalid1), 0);
        chk("midrst state", 32'(dut.r_state), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(mk(1, 0, 8'h12, 16'h0000, 1, 0, 8'h13, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("postrst rvalid1", 32'(rvalid1), 0);
        chk("postrst gnt0", 32'(gnt0), 1);
        chk("postrst gnt1", 32'(gnt1), 0);
        @(posedge clk);
        #1;
        drive(vecs[0]);
        @(negedge clk);
        chk("postrst rvalid0", 32'(rvalid0), 1);
        chk("postrst rdata0", 32'(rdata0), 32'h0000A5A5);
        chk("postrst rvalid1b", 32'(rvalid1), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_ram_arbiter
`default_nettype wire

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single 256x16 synchronous RAM between two requesters.
  - Port 0: the CPU.
  - Port 1: the program loader/debug port.
- Sits between both requesters and the ram instance. Drives its write-enable, read/write address and write-data inputs, and returns read data.
- Uses round-robin arbitration. Port 1 can lock the RAM for burst loads, with a starvation guard that protects the CPU.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 16, RAM word width.
- MAX_WAIT, 4, cycles port 0 may be refused during a port-1 lock before it is forced a grant (1..15).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0  input  1  port 0 access request; held until gnt0.
- we0  input  1  port 0 write (1) / read (0).
- addr0  input  ADDR_W  port 0 address.
- wdata0  input  DATA_W  port 0 write data.
- gnt0  output  1  port 0 accepted this cycle (combinational).
- rvalid0  output  1  port 0 read data valid (registered).
- rdata0  output  DATA_W  port 0 read data.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1.
- lock1  input  1  port 1 requests exclusive ownership while high.
- ram_w_en  output  1  to ram write enable.
- ram_r_addr  output  ADDR_W  to ram read address.
- ram_w_addr  output  ADDR_W  to ram write address.
- ram_w_data  output  DATA_W  to ram write data.
- ram_r_data  input  DATA_W  from ram, valid one cycle after address.

Behaviour:
- At most one grant per cycle; gnt0 & gnt1 never both 1.
- The winner's command drives the RAM combinationally in the grant cycle.
  - ram_r_addr = ram_w_addr = winner addr.
  - ram_w_en = winner we.
  - ram_w_data = winner wdata.
- With no grant: ram_w_en = 0; addresses and data hold port-0 values (don't-care).
- Read latency is 1 cycle.
  - A read granted in cycle N gives rvalidX = 1 in cycle N+1, with rdataX = ram_r_data.
  - A write gives no rvalid.
  - rdataX passes ram_r_data through; it is meaningful only while rvalidX = 1.
- State machine, 2 states:
  - RR (round-robin):
    - If only one port requests, it wins.
    - If both request, the port that did not win last wins; the last-winner pointer is updated on each grant.
    - Transition to LOCK1 when port 1 is granted while lock1 = 1.
  - LOCK1:
    - Port 1 wins whenever req1 = 1.
    - Port 0 is granted only when req1 = 0, or when wait_cnt reaches MAX_WAIT.
    - Return to RR on the first cycle lock1 = 0; that cycle is arbitrated as RR.
- wait_cnt (4 bits):
  - Increments each cycle req0 = 1 and gnt0 = 0 in LOCK1.
  - Clears on gnt0 or on leaving LOCK1.
  - Saturates at MAX_WAIT.
  - A forced port-0 grant does not exit LOCK1.
- Reset (async, any time, including mid-access):
  - state = RR; last-winner = port 1 so port 0 wins the first tie; wait_cnt = 0; rvalid0 = rvalid1 = 0.
  - gnt0, gnt1 and ram_w_en forced 0 while rst = 1.
  - A read granted in the cycle rst asserts never produces rvalid.
- Requests whose req drops before grant are simply dropped; no queuing.
- lock1 without req1 keeps LOCK1 but does not block port 0, since port 0 wins when req1 = 0.

Decomposition:
- Shared package: arb_state_t enum {RR, LOCK1}, default MAX_WAIT constant, port index constants P_CPU = 0, P_LDR = 1.
- One natural sub-module: rr_pick (2-way round-robin picker; inputs req[1:0], last winner; output one-hot grant). All other logic is in ram_arbiter.

Test Plan:
- Reset, then req0 read addr 8'h10 (RAM word 16'h1234) -> gnt0 same cycle, rvalid0 next cycle with rdata0 = 16'h1234, rvalid1 = 0.
- req0 and req1 both held for 4 cycles, reads -> grants alternate 0,1,0,1; each rvalid one cycle after its grant.
- Port 1 write addr 8'h20 data 16'hBEEF, then port 0 read 8'h20 -> ram_w_en = 1 only in port 1's grant cycle; rdata0 = 16'hBEEF.
- lock1 = 1 with req1 held continuously and req0 held, MAX_WAIT = 4 -> port 1 granted 4 cycles, forced gnt0 on the 5th, port 1 resumes; wait_cnt back to 0.
- rst pulsed high for one cycle in the cycle a port-1 read is granted while in LOCK1 -> no rvalid1, state = RR, next simultaneous request granted to port 0.
- req0 asserted then dropped during a port-1 lock before grant -> no gnt0, no RAM write, wait_cnt clears when lock1 drops.
